// File: rtl/aes_v2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_v2_pkg
// Description : Shared definitions for the lightweight AES v2 instruction
//               units: FSM state encodings, S-box affine constants, the
//               GF(2^8) reduction polynomial and small field-arithmetic
//               helper functions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package aes_v2_pkg;

    // Serial-unit FSM encodings
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_busy = 2'd1;
    localparam state_t c_st_done = 2'd2;

    // S-box affine constants
    localparam logic [7:0] c_aff_fwd = 8'h63;
    localparam logic [7:0] c_aff_inv = 8'h05;

    // Low byte of x^8 + x^4 + x^3 + x + 1; also used by the mix unit's xtime
    localparam logic [7:0] c_gf_poly = 8'h1b;

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? c_gf_poly : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add form
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 = prod_{k=1..7} x^(2^k); maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = 8'h01;
        pw  = x;
        for (int k = 1; k < 8; k++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        return acc;
    endfunction

    // Rotate a byte left
    function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
        logic [15:0] d;
        d = {a, a} << (n % 8);
        return d[15:8];
    endfunction

endpackage : aes_v2_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES S-box, forward or inverse. One GF(2^8)
//               inverter is shared by both directions; only the affine
//               stage placement differs (after the inverter for forward,
//               before it for inverse).
// Ports       : in   [7:0]  byte to substitute
//               fwd         1 = forward S-box, 0 = inverse S-box
//               out  [7:0]  substituted byte
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_v2_pkg::*;
(
    input  logic [7:0] in,
    input  logic       fwd,
    output logic [7:0] out
);

    logic [7:0] w_inv_aff;   // inverse affine of the input
    logic [7:0] w_inv_in;    // inverter operand
    logic [7:0] w_inv_out;   // inverter result
    logic [7:0] w_fwd_aff;   // forward affine of the inverter result

    // Inverse affine: b ^= rotl1 ^ rotl3 ^ rotl6, then add 0x05 (no self term)
    assign w_inv_aff = rotl8(in, 1) ^ rotl8(in, 3) ^ rotl8(in, 6) ^ c_aff_inv;

    assign w_inv_in  = fwd ? in : w_inv_aff;
    assign w_inv_out = gf_inv(w_inv_in);

    // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    assign w_fwd_aff = w_inv_out ^ rotl8(w_inv_out, 1) ^ rotl8(w_inv_out, 2)
                     ^ rotl8(w_inv_out, 3) ^ rotl8(w_inv_out, 4) ^ c_aff_fwd;

    assign out = fwd ? w_fwd_aff : w_inv_out;

endmodule : aes_sbox
`default_nettype wire

// File: rtl/aes_v2_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : aes_v2_sub_serial
// Description : Byte-serial AES SubBytes instruction unit. Four operand
//               bytes (taken from the same lanes as the MixColumns unit) are
//               pushed through one shared S-box, one byte per cycle, with a
//               multi-cycle valid/ready handshake.
// Ports       : g_clk          clock, rising edge
//               g_reset        asynchronous active-high reset
//               valid          request; held with stable operands until ready
//               rs1  [31:0]    bytes [7:0] -> b0, [15:8] -> b1
//               rs2  [31:0]    bytes [23:16] -> b2, [31:24] -> b3
//               enc            1 = forward S-box, 0 = inverse S-box
//               ready          one-cycle pulse, rd valid in this cycle
//               rd   [31:0]    {S(b3), S(b2), S(b1), S(b0)}
// Revision    : 1.0 - initial release
// ============================================================================
module aes_v2_sub_serial
    import aes_v2_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] rd
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_ctr;
    logic [31:0] r_ops;       // {b3, b2, b1, b0}
    logic        r_enc;
    logic [31:0] r_rd;
    logic        r_ready;

    // Control strobes from the output decoder
    logic        w_latch;     // capture operands, clear counter
    logic        w_write;     // write S(b[ctr]) into result byte ctr
    logic        w_ready_nxt;

    // Datapath
    logic [7:0]  w_sbox_in;
    logic [7:0]  w_sbox_out;

    // Operand bits outside the selected lanes carry no meaning here
    logic        w_unused_bits;
    assign w_unused_bits = ^{rs1[31:16], rs2[15:0]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (valid) w_state_nxt = c_st_busy;
            end
            c_st_busy: begin
                // A dropped request abandons the operation without a pulse
                if (!valid)             w_state_nxt = c_st_idle;
                else if (r_ctr == 2'd3) w_state_nxt = c_st_done;
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_latch     = 1'b0;
        w_write     = 1'b0;
        w_ready_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_latch = valid;
            end
            c_st_busy: begin
                w_write     = valid;
                w_ready_nxt = valid && (r_ctr == 2'd3);
            end
            default: begin
                w_latch     = 1'b0;
                w_write     = 1'b0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared S-box fed from the latched operand, byte chosen by counter
    // ------------------------------------------------------------------
    always_comb begin
        w_sbox_in = r_ops[7:0];
        case (r_ctr)
            2'd0: w_sbox_in = r_ops[7:0];
            2'd1: w_sbox_in = r_ops[15:8];
            2'd2: w_sbox_in = r_ops[23:16];
            2'd3: w_sbox_in = r_ops[31:24];
            default: w_sbox_in = r_ops[7:0];
        endcase
    end

    aes_sbox u_sbox (
        .in  (w_sbox_in),
        .fwd (r_enc),
        .out (w_sbox_out)
    );

    // ------------------------------------------------------------------
    // Operand latch, counter, result register, ready pulse
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_ops   <= 32'h0;
            r_enc   <= 1'b0;
            r_ctr   <= 2'd0;
            r_rd    <= 32'h0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            if (w_latch) begin
                r_ops <= {rs2[31:24], rs2[23:16], rs1[15:8], rs1[7:0]};
                r_enc <= enc;
                r_ctr <= 2'd0;
            end else if (w_write) begin
                case (r_ctr)
                    2'd0: r_rd[7:0]   <= w_sbox_out;
                    2'd1: r_rd[15:8]  <= w_sbox_out;
                    2'd2: r_rd[23:16] <= w_sbox_out;
                    2'd3: r_rd[31:24] <= w_sbox_out;
                    default: r_rd[7:0] <= w_sbox_out;
                endcase
                r_ctr <= r_ctr + 2'd1;
            end
        end
    end

    assign ready = r_ready;
    assign rd    = r_rd;

endmodule : aes_v2_sub_serial
`default_nettype wire

// File: tb/tb_aes_v2_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_v2_sub_serial
// Description : Directed self-checking bench for aes_v2_sub_serial using
//               hand-computed S-box vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_v2_sub_serial;

    logic        g_clk;
    logic        g_reset;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready;
    logic [31:0] rd;

    int n_tests;
    int n_fail;

    aes_v2_sub_serial u_dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .valid   (valid),
        .rs1     (rs1),
        .rs2     (rs2),
        .enc     (enc),
        .ready   (ready),
        .rd      (rd)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample just after it
    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    // Issue a request and count cycles until ready (bounded). Optionally
    // scramble the operand inputs once the operation is latched.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic e, input logic [31:0] exp_rd, input bit scramble);
        int lat;
        lat   = 0;
        rs1   = a;
        rs2   = b;
        enc   = e;
        valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (scramble && k == 1) begin
                rs1 = 32'h5A5A_5A5A;
                rs2 = 32'hA5A5_A5A5;
                enc = ~e;
            end
            if (ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        valid = 1'b0;
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_rd"}, rd, exp_rd);
        step();
        chk({tag, "_pulse"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        int lat1;
        int lat2;
        bit saw;
        n_tests = 0;
        n_fail  = 0;
        valid   = 1'b0;
        rs1     = 32'h0;
        rs2     = 32'h0;
        enc     = 1'b0;
        g_reset = 1'b1;
        repeat (3) step();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd", rd, 32'h0);
        g_reset = 1'b0;
        step();

        // Basic vectors
        run_op("fwd", 32'h0000_0100, 32'hFF53_0000, 1'b1, 32'h16ED_7C63, 1'b0);
        run_op("inv", 32'h0000_7C63, 32'h16ED_0000, 1'b0, 32'hFF53_0100, 1'b0);
        run_op("ign", 32'hABCD_0100, 32'hFF53_EF12, 1'b1, 32'h16ED_7C63, 1'b0);
        run_op("fwd2", 32'h0000_2010, 32'h4030_0000, 1'b1, 32'h0904_B7CA, 1'b0);
        run_op("inv2", 32'h0000_B7CA, 32'h0904_0000, 1'b0, 32'h4030_2010, 1'b0);
        // Inputs changing during BUSY must not matter
        run_op("scr", 32'h0000_0100, 32'hFF53_0000, 1'b1, 32'h16ED_7C63, 1'b1);

        // Abort: valid low at the 2nd BUSY edge
        rs1   = 32'h0000_2010;
        rs2   = 32'h4030_0000;
        enc   = 1'b1;
        valid = 1'b1;
        step();            // edge N: BUSY
        step();            // 1st BUSY edge: byte 0
        valid = 1'b0;
        saw   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ready === 1'b1) saw = 1'b1;
        end
        chk("abort_noready", {31'd0, saw}, 32'd0);
        run_op("after_abort", 32'h0000_0100, 32'hFF53_0000, 1'b1, 32'h16ED_7C63, 1'b0);

        // Reset in the middle of an operation
        rs1   = 32'h0000_0100;
        rs2   = 32'hFF53_0000;
        enc   = 1'b1;
        valid = 1'b1;
        step();
        step();
        step();            // two bytes written, rd non-zero
        g_reset = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_rd", rd, 32'h0);
        valid = 1'b0;
        step();
        g_reset = 1'b0;
        step();
        run_op("after_rst", 32'h0000_7C63, 32'h16ED_0000, 1'b0, 32'hFF53_0100, 1'b0);

        // Back-to-back: valid held through ready, second op uses new operands
        lat1  = 0;
        lat2  = 0;
        rs1   = 32'h0000_0100;
        rs2   = 32'hFF53_0000;
        enc   = 1'b1;
        valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ready === 1'b1) begin
                lat1 = k;
                break;
            end
        end
        chk("b2b_lat1", lat1, 5);
        chk("b2b_rd1", rd, 32'h16ED_7C63);
        rs1 = 32'h0000_B7CA;
        rs2 = 32'h0904_0000;
        enc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ready === 1'b1) begin
                lat2 = k;
                break;
            end
        end
        valid = 1'b0;
        chk("b2b_lat2", lat2, 6);
        chk("b2b_rd2", rd, 32'h4030_2010);
        step();
        chk("b2b_pulse", {31'd0, ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_aes_v2_sub_serial
`default_nettype wire
